regfile_wb_queue: RTL and testbench

REGFILE_WB_QUEUE -- requirements
Module: regfile_wb_queue

---
 rtl/regfile_wb_queue_pkg.sv | 24 ++
 rtl/regfile_wb_match.sv | 50 +++++
 rtl/regfile_wb_queue.sv | 200 ++++++++++++++++++++
 tb/tb_regfile_wb_queue.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_wb_queue_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue_pkg
//  Description : Shared definitions for the register-file writeback queue:
//                register address width, the hard-wired zero register and
//                the queue entry layout {addr, data}.
//  Revision    : 1.0 - initial release
// ============================================================================
//  The entry data field is sized for the widest supported WIDTH; narrower
//  configurations store their data in the low bits and leave the rest zero.
// ============================================================================
package regfile_wb_queue_pkg;

    localparam int                    REG_ADDR_W    = 5;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG      = '0;
    localparam int                    WB_DATA_MAX_W = 64;

    typedef struct packed {
        logic [REG_ADDR_W-1:0]    addr;
        logic [WB_DATA_MAX_W-1:0] data;
    } wb_entry_t;

endpackage : regfile_wb_queue_pkg
`default_nettype wire

// File: rtl/regfile_wb_match.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_match
//  Description : Youngest-match search for one register read port against
//                the valid entries of the writeback queue.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Ports
//    rd_ptr_i     in   queue head (oldest entry) index
//    count_i      in   queue occupancy at the start of the cycle
//    slot_addr_i  in   destination address held in every storage slot
//    raddr_i      in   read address issued by the pipeline
//    sel_o        out  one-hot slot select of the youngest matching entry,
//                      all zero when nothing matches or raddr_i is r0
// ============================================================================
module regfile_wb_match
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic [$clog2(DEPTH)-1:0] rd_ptr_i,
    input  logic [$clog2(DEPTH):0]   count_i,
    input  logic [REG_ADDR_W-1:0]    slot_addr_i [DEPTH],
    input  logic [REG_ADDR_W-1:0]    raddr_i,
    output logic [DEPTH-1:0]         sel_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] w_idx;

    // Walk from oldest to youngest; a later hit replaces an earlier one so
    // the surviving select always points at the youngest matching entry.
    always_comb begin
        sel_o = '0;
        w_idx = rd_ptr_i;
        if (raddr_i != ZERO_REG) begin
            for (int i = 0; i < DEPTH; i++) begin
                w_idx = rd_ptr_i + PTR_W'(i);
                if ((CNT_W'(i) < count_i) && (slot_addr_i[w_idx] == raddr_i)) begin
                    sel_o        = '0;
                    sel_o[w_idx] = 1'b1;
                end
            end
        end
    end

endmodule : regfile_wb_match
`default_nettype wire

// File: rtl/regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_queue
//  Description : In-order writeback queue in front of a register file. Accepts
//                (addr, data) writebacks, drains one per cycle unless held,
//                and flags reads that target a still-queued register.
//  Revision    : 1.0 - initial release
// ============================================================================
//  Configuration macro
//    REGFILE_WB_BYPASS_EN  defined   : pending reads are served from the
//                                      youngest queued entry (FwdkValid/Data)
//                          undefined : pending reads stall (Stallk), no
//                                      forwarding mux is built
//  Ports
//    Clk, Rst_n                       clock, synchronous active-low reset
//    InValid/InAddr/InData/InReady    writeback request handshake
//    WbHold                           pause draining
//    RegWrite/WriteRegister/WriteData register file write port
//    ReadRegister1/2                  read addresses being issued
//    Stall1/2, Fwd1/2Valid, Fwd1/2Data per-port hazard resolution
//    Count                            current occupancy
// ============================================================================
module regfile_wb_queue
    import regfile_wb_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic                   InValid,
    input  logic [REG_ADDR_W-1:0]  InAddr,
    input  logic [WIDTH-1:0]       InData,
    output logic                   InReady,
    input  logic                   WbHold,
    output logic                   RegWrite,
    output logic [REG_ADDR_W-1:0]  WriteRegister,
    output logic [WIDTH-1:0]       WriteData,
    input  logic [REG_ADDR_W-1:0]  ReadRegister1,
    input  logic [REG_ADDR_W-1:0]  ReadRegister2,
    output logic                   Stall1,
    output logic                   Stall2,
    output logic                   Fwd1Valid,
    output logic                   Fwd2Valid,
    output logic [WIDTH-1:0]       Fwd1Data,
    output logic [WIDTH-1:0]       Fwd2Data,
    output logic [$clog2(DEPTH):0] Count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]      count_q,  count_d;

    logic                  w_push;
    logic                  w_pop;
    wb_entry_t             w_new;
    logic [REG_ADDR_W-1:0] w_slot_addr [DEPTH];
    logic [WIDTH-1:0]      w_slot_data [DEPTH];
    logic [DEPTH-1:0]      w_sel1;
    logic [DEPTH-1:0]      w_sel2;
    logic                  w_pend1;
    logic                  w_pend2;

    // ------------------------------------------------------------------
    // Handshake and drain: both derived from registered occupancy only.
    // ------------------------------------------------------------------
    assign InReady  = (count_q != CNT_W'(DEPTH));
    assign w_pop    = (count_q != '0) && !WbHold;
    // Writes to r0 complete the handshake but are never stored.
    assign w_push   = InValid && InReady && (InAddr != ZERO_REG);
    assign RegWrite = w_pop;
    assign Count    = count_q;

    always_comb begin
        w_new                  = '0;
        w_new.addr             = InAddr;
        w_new.data[WIDTH-1:0]  = InData;
    end

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
            assign w_slot_addr[gi] = mem_q[gi].addr;
            assign w_slot_data[gi] = mem_q[gi].data[WIDTH-1:0];
        end

        // The upper data bits of a narrow configuration are stored as zero
        // and never read; fold them into a sink so they stay accounted for.
        if (WIDTH < WB_DATA_MAX_W) begin : g_pad
            logic w_unused_pad;
            always_comb begin
                w_unused_pad = 1'b0;
                for (int i = 0; i < DEPTH; i++) begin
                    w_unused_pad = w_unused_pad ^ (^mem_q[i].data[WB_DATA_MAX_W-1:WIDTH]);
                end
            end
        end
    endgenerate

    assign WriteRegister = w_slot_addr[rd_ptr_q];
    assign WriteData     = w_slot_data[rd_ptr_q];

    // ------------------------------------------------------------------
    // Pointer / occupancy next state
    // ------------------------------------------------------------------
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage carries no reset; validity is defined by the pointers alone.
    always_ff @(posedge Clk) begin
        if (Rst_n && w_push) begin
            mem_q[wr_ptr_q] <= w_new;
        end
    end

    // ------------------------------------------------------------------
    // Read-port hazard search (state at start of cycle only)
    // ------------------------------------------------------------------
    regfile_wb_match #(
        .DEPTH (DEPTH)
    ) u_match1 (
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .slot_addr_i (w_slot_addr),
        .raddr_i     (ReadRegister1),
        .sel_o       (w_sel1)
    );

    regfile_wb_match #(
        .DEPTH (DEPTH)
    ) u_match2 (
        .rd_ptr_i    (rd_ptr_q),
        .count_i     (count_q),
        .slot_addr_i (w_slot_addr),
        .raddr_i     (ReadRegister2),
        .sel_o       (w_sel2)
    );

    assign w_pend1 = |w_sel1;
    assign w_pend2 = |w_sel2;

`ifdef REGFILE_WB_BYPASS_EN
    // Selects are one-hot, so an AND-OR mux picks the youngest entry.
    always_comb begin
        Fwd1Data = '0;
        Fwd2Data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_sel1[i]) begin
                Fwd1Data = Fwd1Data | w_slot_data[i];
            end
            if (w_sel2[i]) begin
                Fwd2Data = Fwd2Data | w_slot_data[i];
            end
        end
    end

    assign Fwd1Valid = w_pend1;
    assign Fwd2Valid = w_pend2;
    assign Stall1    = 1'b0;
    assign Stall2    = 1'b0;
`else
    assign Fwd1Valid = 1'b0;
    assign Fwd2Valid = 1'b0;
    assign Fwd1Data  = '0;
    assign Fwd2Data  = '0;
    assign Stall1    = w_pend1;
    assign Stall2    = w_pend2;
`endif

endmodule : regfile_wb_queue
`default_nettype wire

// File: tb/tb_regfile_wb_queue.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regfile_wb_queue
//  Description : Scoreboard bench for regfile_wb_queue. Directed stimulus
//                pushes expected writes into a queue; a negedge monitor pops
//                and compares every register-file write the DUT issues.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile_wb_queue;

    localparam int DEPTH = 4;
    localparam int WIDTH = 32;

    logic             Clk;
    logic             Rst_n;
    logic             InValid;
    logic [4:0]       InAddr;
    logic [WIDTH-1:0] InData;
    logic             InReady;
    logic             WbHold;
    logic             RegWrite;
    logic [4:0]       WriteRegister;
    logic [WIDTH-1:0] WriteData;
    logic [4:0]       ReadRegister1;
    logic [4:0]       ReadRegister2;
    logic             Stall1, Stall2;
    logic             Fwd1Valid, Fwd2Valid;
    logic [WIDTH-1:0] Fwd1Data, Fwd2Data;
    logic [2:0]       Count;

    typedef struct {
        logic [4:0]       a;
        logic [WIDTH-1:0] d;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_pass   = 0;

`ifdef REGFILE_WB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    regfile_wb_queue #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .Clk           (Clk),
        .Rst_n         (Rst_n),
        .InValid       (InValid),
        .InAddr        (InAddr),
        .InData        (InData),
        .InReady       (InReady),
        .WbHold        (WbHold),
        .RegWrite      (RegWrite),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .Stall1        (Stall1),
        .Stall2        (Stall2),
        .Fwd1Valid     (Fwd1Valid),
        .Fwd2Valid     (Fwd2Valid),
        .Fwd1Data      (Fwd1Data),
        .Fwd2Data      (Fwd2Data),
        .Count         (Count)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] a, input logic [WIDTH-1:0] d);
        InValid = v;
        InAddr  = a;
        InData  = d;
    endtask

    task automatic expect_wb(input logic [4:0] a, input logic [WIDTH-1:0] d);
        exp_t e;
        e.a = a;
        e.d = d;
        exp_q.push_back(e);
    endtask

    // Monitor: every issued write must match the oldest expected entry.
    always @(negedge Clk) begin : mon
        exp_t e;
        if (Rst_n && RegWrite) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wb_unexpected: got write r%0d=0x%0h, required no write", WriteRegister, WriteData);
            end else begin
                e = exp_q.pop_front();
                chk("wb_addr", 64'(WriteRegister), 64'(e.a));
                chk("wb_data", 64'(WriteData), 64'(e.d));
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        Rst_n = 1'b0;
        WbHold = 1'b0;
        ReadRegister1 = '0;
        ReadRegister2 = '0;
        drive(1'b0, 5'd0, '0);
        tick();
        tick();
        Rst_n = 1'b1;

        // ---------------- reset state ----------------
        @(negedge Clk);
        chk("rst_inready", 64'(InReady), 64'd1);
        chk("rst_regwrite", 64'(RegWrite), 64'd0);
        chk("rst_count", 64'(Count), 64'd0);
        chk("rst_stall", 64'({Stall1, Stall2}), 64'd0);
        chk("rst_fwdvalid", 64'({Fwd1Valid, Fwd2Valid}), 64'd0);
        chk("rst_fwddata", {Fwd1Data, Fwd2Data}, 64'd0);

        // ---------------- single push, latency ----------------
        tick();
        drive(1'b1, 5'd3, 32'hAAAA_0001);
        expect_wb(5'd3, 32'hAAAA_0001);
        @(negedge Clk);
        chk("lat_no_passthru", 64'(RegWrite), 64'd0);
        tick();
        drive(1'b0, 5'd0, '0);
        @(negedge Clk);
        chk("lat_regwrite", 64'(RegWrite), 64'd1);
        chk("lat_count1", 64'(Count), 64'd1);
        tick();
        @(negedge Clk);
        chk("lat_count0", 64'(Count), 64'd0);

        // ---------------- fill under hold ----------------
        tick();
        WbHold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'(10 + i), 32'hB000_0000 + 32'(i));
            expect_wb(5'(10 + i), 32'hB000_0000 + 32'(i));
            tick();
        end
        drive(1'b1, 5'd20, 32'hDEAD_BEEF);
        @(negedge Clk);
        chk("full_count", 64'(Count), 64'd4);
        chk("full_inready", 64'(InReady), 64'd0);
        tick();
        drive(1'b0, 5'd0, '0);
        WbHold = 1'b0;
        @(negedge Clk);
        chk("full_pop_inready", 64'(InReady), 64'd0);
        for (int k = 0; k < 4; k++) begin
            if (k != 0) @(negedge Clk);
            chk("drain_regwrite", 64'(RegWrite), 64'd1);
            chk("drain_count", 64'(Count), 64'(4 - k));
            tick();
        end
        @(negedge Clk);
        chk("drain_done_rw", 64'(RegWrite), 64'd0);
        chk("drain_done_count", 64'(Count), 64'd0);

        // ---------------- write to r0 ----------------
        tick();
        drive(1'b1, 5'd0, 32'h0000_1234);
        @(negedge Clk);
        chk("r0_inready", 64'(InReady), 64'd1);
        tick();
        drive(1'b0, 5'd0, '0);
        @(negedge Clk);
        chk("r0_count", 64'(Count), 64'd0);
        chk("r0_regwrite", 64'(RegWrite), 64'd0);
        tick();

        // ---------------- hazard match / forwarding ----------------
        WbHold = 1'b1;
        drive(1'b1, 5'd7, 32'h11);
        expect_wb(5'd7, 32'h11);
        tick();
        drive(1'b1, 5'd7, 32'h22);
        expect_wb(5'd7, 32'h22);
        tick();
        drive(1'b1, 5'd9, 32'h99);
        expect_wb(5'd9, 32'h99);
        ReadRegister1 = 5'd7;
        ReadRegister2 = 5'd9;
        @(negedge Clk);
        chk("hz1_fwdvalid", 64'(Fwd1Valid), 64'(BYP));
        chk("hz1_fwddata", 64'(Fwd1Data), BYP ? 64'h22 : 64'h0);
        chk("hz1_stall", 64'(Stall1), 64'(!BYP));
        chk("hz2_incoming_stall", 64'(Stall2), 64'd0);
        chk("hz2_incoming_fwd", 64'(Fwd2Valid), 64'd0);
        tick();
        drive(1'b0, 5'd0, '0);
        @(negedge Clk);
        chk("hz2_queued_fwd", 64'({Fwd2Valid, Fwd2Data}), BYP ? {31'd0, 1'b1, 32'h99} : 64'd0);
        chk("hz2_queued_stall", 64'(Stall2), 64'(!BYP));
        ReadRegister2 = 5'd0;
        #1;
        chk("hz2_zero_stall", 64'(Stall2), 64'd0);
        chk("hz2_zero_fwd", 64'(Fwd2Valid), 64'd0);
        tick();
        WbHold = 1'b0;
        @(negedge Clk);
        // head (7,0x11) is draining; the younger (7,0x22) still wins
        chk("hz1_drain_data", 64'(Fwd1Data), BYP ? 64'h22 : 64'h0);
        chk("hz1_drain_stall", 64'(Stall1), 64'(!BYP));
        tick();
        tick();
        tick();
        @(negedge Clk);
        chk("hz_done_count", 64'(Count), 64'd0);
        chk("hz_done_stall", 64'(Stall1), 64'd0);
        ReadRegister1 = 5'd0;

        // ---------------- simultaneous push/pop across wrap ----------------
        tick();
        WbHold = 1'b1;
        drive(1'b1, 5'd1, 32'hC100);
        expect_wb(5'd1, 32'hC100);
        tick();
        drive(1'b1, 5'd2, 32'hC200);
        expect_wb(5'd2, 32'hC200);
        tick();
        WbHold = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 5'(11 + i), 32'hC0 + 32'(i));
            expect_wb(5'(11 + i), 32'hC0 + 32'(i));
            @(negedge Clk);
            chk("pp_count", 64'(Count), 64'd2);
            tick();
        end
        drive(1'b0, 5'd0, '0);
        tick();
        tick();
        @(negedge Clk);
        chk("pp_done_count", 64'(Count), 64'd0);

        // ---------------- reset mid-drain ----------------
        tick();
        WbHold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'(21 + i), 32'hE0 + 32'(i));
            tick();
        end
        Rst_n  = 1'b0;
        WbHold = 1'b0;
        drive(1'b1, 5'd24, 32'hE9);
        tick();
        Rst_n = 1'b1;
        drive(1'b0, 5'd0, '0);
        @(negedge Clk);
        chk("rstmid_count", 64'(Count), 64'd0);
        chk("rstmid_regwrite", 64'(RegWrite), 64'd0);
        chk("rstmid_inready", 64'(InReady), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        @(negedge Clk);
        chk("rstmid_count_later", 64'(Count), 64'd0);
        chk("sb_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_regfile_wb_queue
`default_nettype wire
